// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the rv_core Wishbone interconnect.
// - wb_state_e : interconnect cycle state
// - wb_req_t   : master request captured in IDLE and driven onto the shared slave bus
package rv_wb_pkg;

  localparam int unsigned NSLAVE_MAX = 8;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } wb_state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/rv_wb_interconnect_decode.sv
// Combinational address decoder.
// Ports:
//   adr       in  32      address to decode
//   hit       out NSLAVE  one-hot hit vector (lowest matching index only)
//   hit_valid out 1       some slave window matched
module rv_wb_interconnect_decode #(
  parameter int unsigned               NSLAVE   = 4,
  parameter logic [NSLAVE-1:0][31:0]   SLV_BASE = '0,
  parameter logic [NSLAVE-1:0][31:0]   SLV_MASK = '0
) (
  input  logic [31:0]       adr,
  output logic [NSLAVE-1:0] hit,
  output logic              hit_valid
);

  always_comb begin
    hit       = '0;
    hit_valid = 1'b0;
    // Ascending scan; the first match blocks later ones so overlaps resolve to the lowest index.
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (!hit_valid && ((adr & SLV_MASK[i]) == SLV_BASE[i])) begin
        hit[i]    = 1'b1;
        hit_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv_wb_interconnect.sv
// Registered Wishbone-classic interconnect: one rv_core master to NSLAVE slaves.
// Runs exactly one slave cycle per master request, traps unmapped and timed-out
// accesses with ack+err, and records the address of the first fault.
// Ports:
//   i_clk, i_reset_n               clock, async active-low reset
//   i_m_*                          master request (adr/dat/we/sel/stb/cyc)
//   o_m_dat, o_m_ack, o_m_err      master response
//   o_s_adr/dat/we/sel             shared registered slave request
//   o_s_stb, o_s_cyc               one-hot slave select
//   i_s_dat, i_s_ack               slave responses, slave i at [32i+:32]
//   i_fault_clr                    clear the fault record
//   o_fault_valid, o_fault_adr     first recorded fault
module rv_wb_interconnect
  import rv_wb_pkg::*;
#(
  parameter int unsigned             NSLAVE   = 4,
  parameter logic [NSLAVE-1:0][31:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                 32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLAVE-1:0][31:0] SLV_MASK = {NSLAVE{32'hF000_0000}},
  parameter int unsigned             TIMEOUT  = 16,
  parameter logic [31:0]             ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [31:0]          i_m_adr,
  input  logic [31:0]          i_m_dat,
  input  logic                 i_m_we,
  input  logic [3:0]           i_m_sel,
  input  logic                 i_m_stb,
  input  logic                 i_m_cyc,
  output logic [31:0]          o_m_dat,
  output logic                 o_m_ack,
  output logic                 o_m_err,
  output logic [31:0]          o_s_adr,
  output logic [31:0]          o_s_dat,
  output logic                 o_s_we,
  output logic [3:0]           o_s_sel,
  output logic [NSLAVE-1:0]    o_s_stb,
  output logic [NSLAVE-1:0]    o_s_cyc,
  input  logic [NSLAVE*32-1:0] i_s_dat,
  input  logic [NSLAVE-1:0]    i_s_ack,
  input  logic                 i_fault_clr,
  output logic                 o_fault_valid,
  output logic [31:0]          o_fault_adr
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  wb_state_e         state_q, state_d;
  wb_req_t           req_q, req_d;
  logic [NSLAVE-1:0] stb_q, stb_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       dat_q, dat_d;
  logic              fault_valid_q;
  logic [31:0]       fault_adr_q;

  logic [NSLAVE-1:0] hit;
  logic              hit_valid;
  logic              ack_sel;
  logic [31:0]       rdata_sel;

  rv_wb_interconnect_decode #(
    .NSLAVE  (NSLAVE),
    .SLV_BASE(SLV_BASE),
    .SLV_MASK(SLV_MASK)
  ) u_decode (
    .adr      (i_m_adr),
    .hit      (hit),
    .hit_valid(hit_valid)
  );

  // stb_q is one-hot, so masking selects the addressed slave's ack and data only.
  assign ack_sel = |(i_s_ack & stb_q);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (stb_q[i]) begin
        rdata_sel = rdata_sel | i_s_dat[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    stb_d   = stb_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    dat_d   = dat_q;
    case (state_q)
      StIdle: begin
        if (i_m_cyc && i_m_stb) begin
          req_d.adr = i_m_adr;
          req_d.dat = i_m_dat;
          req_d.we  = i_m_we;
          req_d.sel = i_m_sel;
          if (hit_valid) begin
            stb_d   = hit;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = StReq;
          end else begin
            err_d   = 1'b1;
            if (!i_m_we) dat_d = ERR_DATA;
            state_d = StResp;
          end
        end
      end
      StReq: begin
        if (!i_m_cyc) begin
          // Master abandoned the cycle: drop the slave, no response.
          stb_d   = '0;
          state_d = StIdle;
        end else if (ack_sel) begin
          stb_d   = '0;
          if (!req_q.we) dat_d = rdata_sel;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // Last allowed REQ cycle passed without an ack.
          stb_d   = '0;
          err_d   = 1'b1;
          if (!req_q.we) dat_d = ERR_DATA;
          state_d = StResp;
        end else if (cnt_q != CntW'(TIMEOUT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        stb_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      req_q   <= '0;
      stb_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // A fault arriving with a clear replaces the old record rather than being lost.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fault_valid_q <= 1'b0;
      fault_adr_q   <= '0;
    end else if ((state_q == StResp) && err_q && (!fault_valid_q || i_fault_clr)) begin
      fault_valid_q <= 1'b1;
      fault_adr_q   <= req_q.adr;
    end else if (i_fault_clr) begin
      fault_valid_q <= 1'b0;
    end
  end

  assign o_m_dat       = dat_q;
  assign o_m_ack       = (state_q == StResp);
  assign o_m_err       = (state_q == StResp) && err_q;
  assign o_s_adr       = req_q.adr;
  assign o_s_dat       = req_q.dat;
  assign o_s_we        = req_q.we;
  assign o_s_sel       = req_q.sel;
  assign o_s_stb       = stb_q;
  assign o_s_cyc       = stb_q;
  assign o_fault_valid = fault_valid_q;
  assign o_fault_adr   = fault_adr_q;

endmodule

// File: tb/tb_rv_wb_interconnect.sv
module tb_rv_wb_interconnect;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  m_adr = '0;
  logic [31:0]  m_dat = '0;
  logic         m_we = 1'b0;
  logic [3:0]   m_sel = '0;
  logic         m_stb = 1'b0;
  logic         m_cyc = 1'b0;
  logic [31:0]  m_rdat;
  logic         m_ack;
  logic         m_err;
  logic [31:0]  s_adr;
  logic [31:0]  s_wdat;
  logic         s_we;
  logic [3:0]   s_sel;
  logic [3:0]   s_stb;
  logic [3:0]   s_cyc;
  logic [127:0] s_dat = '0;
  logic [3:0]   s_ack = '0;
  logic         fault_clr = 1'b0;
  logic         fault_valid;
  logic [31:0]  fault_adr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv_wb_interconnect dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_m_adr      (m_adr),
    .i_m_dat      (m_dat),
    .i_m_we       (m_we),
    .i_m_sel      (m_sel),
    .i_m_stb      (m_stb),
    .i_m_cyc      (m_cyc),
    .o_m_dat      (m_rdat),
    .o_m_ack      (m_ack),
    .o_m_err      (m_err),
    .o_s_adr      (s_adr),
    .o_s_dat      (s_wdat),
    .o_s_we       (s_we),
    .o_s_sel      (s_sel),
    .o_s_stb      (s_stb),
    .o_s_cyc      (s_cyc),
    .i_s_dat      (s_dat),
    .i_s_ack      (s_ack),
    .i_fault_clr  (fault_clr),
    .o_fault_valid(fault_valid),
    .o_fault_adr  (fault_adr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                       input logic [3:0] sel);
    m_adr = adr;
    m_dat = dat;
    m_we  = we;
    m_sel = sel;
    m_stb = 1'b1;
    m_cyc = 1'b1;
  endtask

  task automatic release_master();
    m_stb = 1'b0;
    m_cyc = 1'b0;
    s_ack = '0;
  endtask

  int n_stb;
  logic seen_ack;

  initial begin
    // Reset state
    #12;
    check_eq("rst_ack", {31'd0, m_ack}, 32'd0);
    check_eq("rst_stb", {28'd0, s_stb}, 32'd0);
    check_eq("rst_fault_valid", {31'd0, fault_valid}, 32'd0);
    check_eq("rst_mdat", m_rdat, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Read slave1, same-cycle ack
    start(32'h1000_0010, 32'h0, 1'b0, 4'hF);
    s_dat[32 +: 32] = 32'h1234_5678;
    s_ack = 4'b0010;
    @(negedge clk);
    check_eq("t1_stb", {28'd0, s_stb}, 32'h2);
    check_eq("t1_cyc", {28'd0, s_cyc}, 32'h2);
    check_eq("t1_ack_early", {31'd0, m_ack}, 32'd0);
    @(negedge clk);
    check_eq("t1_ack", {31'd0, m_ack}, 32'd1);
    check_eq("t1_err", {31'd0, m_err}, 32'd0);
    check_eq("t1_dat", m_rdat, 32'h1234_5678);
    check_eq("t1_stb_drop", {28'd0, s_stb}, 32'd0);
    release_master();
    @(negedge clk);

    // 2. Write slave0
    start(32'h0000_0004, 32'hA5A5_A5A5, 1'b1, 4'b0011);
    @(negedge clk);
    check_eq("t2_stb", {28'd0, s_stb}, 32'h1);
    check_eq("t2_we", {31'd0, s_we}, 32'd1);
    check_eq("t2_sel", {28'd0, s_sel}, 32'h3);
    check_eq("t2_sdat", s_wdat, 32'hA5A5_A5A5);
    check_eq("t2_sadr", s_adr, 32'h0000_0004);
    s_ack = 4'b0001;
    @(negedge clk);
    check_eq("t2_ack", {31'd0, m_ack}, 32'd1);
    check_eq("t2_err", {31'd0, m_err}, 32'd0);
    release_master();
    @(negedge clk);
    check_eq("t2_single_ack", {31'd0, m_ack}, 32'd0);

    // 3. Unmapped read
    start(32'h5000_0000, 32'h0, 1'b0, 4'hF);
    @(negedge clk);
    check_eq("t3_stb", {28'd0, s_stb}, 32'd0);
    check_eq("t3_ack", {31'd0, m_ack}, 32'd1);
    check_eq("t3_err", {31'd0, m_err}, 32'd1);
    check_eq("t3_dat", m_rdat, 32'hDEAD_BEEF);
    release_master();
    @(negedge clk);
    check_eq("t3_fault_valid", {31'd0, fault_valid}, 32'd1);
    check_eq("t3_fault_adr", fault_adr, 32'h5000_0000);

    // 4a. Slave2 silent: timeout after 16 REQ cycles
    start(32'h2000_0000, 32'h0, 1'b0, 4'hF);
    n_stb = 0;
    seen_ack = 1'b0;
    for (int c = 0; c < 40 && !seen_ack; c++) begin
      @(negedge clk);
      if (s_stb == 4'b0100) n_stb++;
      if (m_ack) seen_ack = 1'b1;
    end
    check_eq("t4_seen_ack", {31'd0, seen_ack}, 32'd1);
    check_eq("t4_stb_cycles", n_stb, 32'd16);
    check_eq("t4_err", {31'd0, m_err}, 32'd1);
    check_eq("t4_dat", m_rdat, 32'hDEAD_BEEF);
    release_master();
    @(negedge clk);
    // 5a. Second fault while valid keeps the first address
    check_eq("t5_fault_kept", fault_adr, 32'h5000_0000);
    check_eq("t5_fault_valid", {31'd0, fault_valid}, 32'd1);

    // 4b. Slave2 acks in the 16th REQ cycle
    start(32'h2000_0040, 32'h0, 1'b0, 4'hF);
    s_dat[64 +: 32] = 32'hCAFE_0016;
    n_stb = 0;
    seen_ack = 1'b0;
    for (int c = 0; c < 40 && !seen_ack; c++) begin
      @(negedge clk);
      if (s_stb == 4'b0100) n_stb++;
      if (n_stb == 16) s_ack = 4'b0100;
      if (m_ack) seen_ack = 1'b1;
    end
    check_eq("t4b_seen_ack", {31'd0, seen_ack}, 32'd1);
    check_eq("t4b_stb_cycles", n_stb, 32'd16);
    check_eq("t4b_err", {31'd0, m_err}, 32'd0);
    check_eq("t4b_dat", m_rdat, 32'hCAFE_0016);
    release_master();
    @(negedge clk);

    // 5b. Clear coinciding with a new fault: new fault wins
    start(32'h7000_0000, 32'h0, 1'b0, 4'hF);
    @(negedge clk);
    check_eq("t5b_err", {31'd0, m_err}, 32'd1);
    fault_clr = 1'b1;
    release_master();
    @(negedge clk);
    fault_clr = 1'b0;
    check_eq("t5b_fault_valid", {31'd0, fault_valid}, 32'd1);
    check_eq("t5b_fault_adr", fault_adr, 32'h7000_0000);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check_eq("t5c_cleared", {31'd0, fault_valid}, 32'd0);

    // 6a. Stray ack from slave3 while slave1 selected
    start(32'h1000_0020, 32'h0, 1'b0, 4'hF);
    s_dat[96 +: 32] = 32'h0000_0BAD;
    s_dat[32 +: 32] = 32'h0000_1111;
    s_ack = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("t6_stray_stb", {28'd0, s_stb}, 32'h2);
      check_eq("t6_stray_ack", {31'd0, m_ack}, 32'd0);
    end
    s_ack = 4'b0010;
    @(negedge clk);
    check_eq("t6_ack", {31'd0, m_ack}, 32'd1);
    check_eq("t6_dat", m_rdat, 32'h0000_1111);
    release_master();
    @(negedge clk);

    // Abort: master drops cyc mid-REQ
    start(32'h2000_0000, 32'h0, 1'b0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    release_master();
    @(negedge clk);
    check_eq("abort_stb", {28'd0, s_stb}, 32'd0);
    check_eq("abort_ack", {31'd0, m_ack}, 32'd0);
    @(negedge clk);
    check_eq("abort_no_ack", {31'd0, m_ack}, 32'd0);

    // 6b. Reset mid-REQ drops stb/cyc without a clock edge
    start(32'h2000_0000, 32'h0, 1'b0, 4'hF);
    @(negedge clk);
    check_eq("t6r_stb_before", {28'd0, s_stb}, 32'h4);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6r_stb_async", {28'd0, s_stb}, 32'd0);
    check_eq("t6r_cyc_async", {28'd0, s_cyc}, 32'd0);
    release_master();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start(32'h0000_0100, 32'h0, 1'b0, 4'hF);
    s_dat[0 +: 32] = 32'h600D_0000;
    s_ack = 4'b0001;
    @(negedge clk);
    check_eq("t6r_post_stb", {28'd0, s_stb}, 32'h1);
    @(negedge clk);
    check_eq("t6r_post_ack", {31'd0, m_ack}, 32'd1);
    check_eq("t6r_post_dat", m_rdat, 32'h600D_0000);
    release_master();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
